// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
package fetch_pkg;

    localparam int              ADDR_W_DEF   = 16;
    localparam int              DATA_W_DEF   = 16;
    localparam int              DEPTH_DEF    = 2;
    localparam logic [15:0]     RESET_PC_DEF = 16'h0000;

    // Fetch control state, also exported on state_dbg.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    // Layout of one buffered instruction for the default widths.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] pc;
        logic [DATA_W_DEF-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer: DEPTH entries of {pc, instr}, registered head,
// synchronous flush. Push and pop may coincide even when full.
module fetch_fifo #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic [DATA_W-1:0] push_instr,
    input  logic              pop,
    output logic [CW-1:0]     count,
    output logic              head_valid,
    output logic [ADDR_W-1:0] head_pc,
    output logic [DATA_W-1:0] head_instr
);

    logic [ADDR_W-1:0] pc_mem    [DEPTH];
    logic [DATA_W-1:0] instr_mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count_nxt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Storage, pointers and count; flush wins over push/pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr]    <= push_pc;
                instr_mem[wr_ptr] <= push_instr;
                wr_ptr            <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count_nxt;
        end
    end

    assign head_valid = (count != '0);
    assign head_pc    = pc_mem[rd_ptr];
    assign head_instr = instr_mem[rd_ptr];

    no_overflow: assert property (@(posedge clk) disable iff (!reset)
        (push && !pop && !flush) |-> (count != CW'(DEPTH)));

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC generation, credit-limited instruction-memory reads,
// redirect with kill of in-flight reads, and a buffered valid/ready
// interface toward the opcode decoder.
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high. imem_req_valid does not depend on imem_req_ready;
// instr_valid does not depend on instr_ready. imem_rsp_valid has no
// backpressure and returns data in request order.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int              ADDR_W   = ADDR_W_DEF,
    parameter int              DATA_W   = DATA_W_DEF,
    parameter int              DEPTH    = DEPTH_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
    localparam int             CW       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instruction,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [1:0]        state_dbg
);

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     outstanding_nxt;
    logic [CW-1:0]     drop_cnt;
    logic [CW-1:0]     fifo_count;
    logic [CW:0]       credit_used;
    logic              fifo_valid;
    logic [ADDR_W-1:0] head_pc;
    logic [DATA_W-1:0] head_instr;
    logic              req_accept;
    logic              pop;
    logic              push;
    logic [ADDR_W-1:0] rsp_pc;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // FSM next state: fetch_en starts/stops issue; DRAIN waits for reads to return.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (fetch_en) state_nxt = ST_RUN;
            ST_RUN:   if (!fetch_en) state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (fetch_en)                 state_nxt = ST_RUN;
                else if (outstanding == '0)   state_nxt = ST_IDLE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: issue only in RUN, never alongside a redirect, and only
    // while every in-flight read still has a buffer slot. The slot freed by
    // this cycle's pop is counted so a full pipeline sustains one per cycle.
    always_comb begin
        credit_used    = {1'b0, outstanding} + {1'b0, fifo_count} - {{CW{1'b0}}, pop};
        imem_req_valid = (state == ST_RUN) && !redirect_valid &&
                         (credit_used < (CW + 1)'(DEPTH));
    end

    // Handshake and response bookkeeping.
    always_comb begin
        instr_valid = fifo_valid && !redirect_valid;
        pop         = instr_valid && instr_ready;
        req_accept  = imem_req_valid && imem_req_ready;
        push        = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);
        // Live (non-dropped) reads are consecutive and end at pc-1, so the
        // oldest one -- the one answering now -- sits that far behind pc.
        rsp_pc      = pc - ADDR_W'(outstanding - drop_cnt);
        outstanding_nxt = outstanding;
        case ({req_accept, imem_rsp_valid})
            2'b10:   outstanding_nxt = outstanding + CW'(1);
            2'b01:   outstanding_nxt = outstanding - CW'(1);
            default: outstanding_nxt = outstanding;
        endcase
    end

    // PC and read counters; a redirect marks every still-pending read for discard.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (redirect_valid) begin
                pc       <= redirect_pc;
                drop_cnt <= outstanding_nxt;
            end else begin
                if (req_accept) pc <= pc + ADDR_W'(1);
                if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    fetch_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (push),
        .push_pc    (rsp_pc),
        .push_instr (imem_rsp_data),
        .pop        (pop),
        .count      (fifo_count),
        .head_valid (fifo_valid),
        .head_pc    (head_pc),
        .head_instr (head_instr)
    );

    assign imem_addr   = pc;
    assign instruction = head_instr;
    assign instr_pc    = head_pc;
    assign state_dbg   = state;

    rsp_needs_read: assert property (@(posedge clk) disable iff (!reset)
        imem_rsp_valid |-> (outstanding != '0));

endmodule
